// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder core.
package spi_pkg;

  // Register word addresses (addr[1:0])
  localparam logic [1:0] ADDR_RX   = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_TX   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Status register bit positions
  localparam int unsigned STAT_RX_VALID    = 0;
  localparam int unsigned STAT_TX_EMPTY    = 1;
  localparam int unsigned STAT_RX_OVERRUN  = 2;
  localparam int unsigned STAT_TX_UNDERRUN = 3;
  localparam int unsigned STAT_SS_ACTIVE   = 4;

  // Byte engine states
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_state_e;

endpackage

// File: rtl/spi_slave.sv
// SPI byte engine: pin synchronizers, SCLK/SS edge detection, shift registers
// and bit counter. Works in all four CPOL/CPHA modes, MSB first.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_byte,
  input  logic       tx_avail,
  output logic       tx_req,
  output logic       rx_done,
  output logic [7:0] rx_byte,
  output logic       spi_miso,
  output logic       spi_miso_en
);

  logic [SYNC-1:0] sclk_sync, ss_sync, mosi_sync;
  logic            sclk_prev, ss_prev;
  logic            sclk_rise_q, sclk_fall_q, ss_fall_q, ss_rise_q, mosi_q;

  spi_state_e      state_q;
  logic            cpol_q, cpha_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_tx_q, shift_rx_q;

  logic            lead_ev, trail_ev, sample_ev, shift_ev;
  logic [7:0]      load_val;

  // Synchronize pins and register edge pulses; MOSI is delayed to line up with them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync   <= '0;
      ss_sync     <= '1;
      mosi_sync   <= '0;
      sclk_prev   <= 1'b0;
      ss_prev     <= 1'b1;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC-2:0], spi_sclk};
      ss_sync     <= {ss_sync[SYNC-2:0], spi_ss_n};
      mosi_sync   <= {mosi_sync[SYNC-2:0], spi_mosi};
      sclk_prev   <= sclk_sync[SYNC-1];
      ss_prev     <= ss_sync[SYNC-1];
      sclk_rise_q <= sclk_sync[SYNC-1] & ~sclk_prev;
      sclk_fall_q <= ~sclk_sync[SYNC-1] & sclk_prev;
      ss_fall_q   <= ~ss_sync[SYNC-1] & ss_prev;
      ss_rise_q   <= ss_sync[SYNC-1] & ~ss_prev;
      mosi_q      <= mosi_sync[SYNC-1];
    end
  end

  // Map raw SCLK edges to leading/trailing and sample/shift using the latched mode
  always_comb begin
    lead_ev   = cpol_q ? sclk_fall_q : sclk_rise_q;
    trail_ev  = cpol_q ? sclk_rise_q : sclk_fall_q;
    sample_ev = cpha_q ? trail_ev : lead_ev;
    shift_ev  = cpha_q ? lead_ev : trail_ev;
    load_val  = tx_avail ? tx_byte : 8'hFF;
    rx_byte   = {shift_rx_q[6:0], mosi_q};
    // In LOAD, the edge that would otherwise shift is the one that loads
    tx_req    = 1'b0;
    rx_done   = 1'b0;
    unique case (state_q)
      IDLE:    tx_req = ss_fall_q & ~cpha;
      LOAD:    tx_req = ~ss_rise_q & shift_ev;
      SHIFT:   rx_done = ~ss_rise_q & sample_ev & (bit_cnt_q == 3'd7);
      default: ;
    endcase
  end

  // Byte engine FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shift_tx_q <= 8'hFF;
      shift_rx_q <= 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_fall_q) begin
            cpol_q    <= cpol;
            cpha_q    <= cpha;
            bit_cnt_q <= 3'd0;
            if (cpha) begin
              state_q <= LOAD;
            end else begin
              shift_tx_q <= load_val;
              state_q    <= SHIFT;
            end
          end
        end
        LOAD: begin
          if (ss_rise_q) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
          end else if (shift_ev) begin
            shift_tx_q <= load_val;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise_q) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
          end else begin
            if (sample_ev) begin
              shift_rx_q <= {shift_rx_q[6:0], mosi_q};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= LOAD;
            end
            if (shift_ev) shift_tx_q <= {shift_tx_q[6:0], 1'b1};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso_en = (state_q != IDLE);
  assign spi_miso    = (state_q == IDLE) ? 1'b1 : shift_tx_q[7];

endmodule

// File: rtl/spi_slave_core.sv
// Memory-mapped SPI responder: bus decode, RX/TX holding registers, status
// flags and mode register around the spi_slave byte engine.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned SYNC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_en
);

  logic [7:0] rx_data_q, tx_data_q;
  logic       rx_valid_q, rx_overrun_q, tx_empty_q, tx_underrun_q;
  logic       cpol_q, cpha_q;
  logic       tx_req, rx_done;
  logic [7:0] rx_byte;
  logic       rx_rd, stat_wr, tx_wr, ctrl_wr;
  logic       unused_bits;

  assign unused_bits = ^{addr[4:2], wr_data[31:8], wr_data[7:4]};

  assign rx_rd   = cs & read  & (addr[1:0] == ADDR_RX);
  assign stat_wr = cs & write & (addr[1:0] == ADDR_STAT);
  assign tx_wr   = cs & write & (addr[1:0] == ADDR_TX);
  assign ctrl_wr = cs & write & (addr[1:0] == ADDR_CTRL);

  spi_slave #(
    .SYNC(SYNC)
  ) u_spi_slave (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_sclk   (spi_sclk),
    .spi_ss_n   (spi_ss_n),
    .spi_mosi   (spi_mosi),
    .cpol       (cpol_q),
    .cpha       (cpha_q),
    .tx_byte    (tx_data_q),
    .tx_avail   (~tx_empty_q),
    .tx_req     (tx_req),
    .rx_done    (rx_done),
    .rx_byte    (rx_byte),
    .spi_miso   (spi_miso),
    .spi_miso_en(spi_miso_en)
  );

  // Holding registers and flags; engine set events take priority over CPU clears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_empty_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_data_q  <= rx_byte;
        rx_valid_q <= 1'b1;
      end else if (rx_rd) begin
        rx_valid_q <= 1'b0;
      end

      // A byte landing during the read of the old one is not an overrun
      if (rx_done && rx_valid_q && !rx_rd) rx_overrun_q <= 1'b1;
      else if (stat_wr && wr_data[2])      rx_overrun_q <= 1'b0;

      // A CPU write always leaves the holding register full, even against a LOAD
      if (tx_wr) begin
        tx_data_q  <= wr_data[7:0];
        tx_empty_q <= 1'b0;
      end else if (tx_req) begin
        tx_empty_q <= 1'b1;
      end

      if (tx_req && tx_empty_q)       tx_underrun_q <= 1'b1;
      else if (stat_wr && wr_data[3]) tx_underrun_q <= 1'b0;

      if (ctrl_wr) begin
        cpol_q <= wr_data[0];
        cpha_q <= wr_data[1];
      end
    end
  end

  // Read mux; unlisted fields read as zero
  always_comb begin
    rd_data = '0;
    case (addr[1:0])
      ADDR_RX: rd_data[7:0] = rx_data_q;
      ADDR_STAT: begin
        rd_data[STAT_RX_VALID]    = rx_valid_q;
        rd_data[STAT_TX_EMPTY]    = tx_empty_q;
        rd_data[STAT_RX_OVERRUN]  = rx_overrun_q;
        rd_data[STAT_TX_UNDERRUN] = tx_underrun_q;
        rd_data[STAT_SS_ACTIVE]   = spi_miso_en;
      end
      ADDR_CTRL: rd_data[1:0] = {cpha_q, cpol_q};
      default: ;
    endcase
  end

endmodule
